// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode bit indices, opcode width and FSM states for alu_pipe
package alu_pkg;

   localparam int OPC_W = 24;

   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_SADR = 2;
   localparam int OP_LADR = 3;
   localparam int OP_SGE  = 5;
   localparam int OP_SLE  = 6;
   localparam int OP_SGT  = 7;
   localparam int OP_SLT  = 8;
   localparam int OP_SEQ  = 9;
   localparam int OP_SNE  = 10;
   localparam int OP_AND  = 11;
   localparam int OP_OR   = 12;
   localparam int OP_XOR  = 13;
   localparam int OP_NOT  = 14;
   localparam int OP_SLI  = 16;
   localparam int OP_SRI  = 17;
   localparam int OP_ADDI = 18;
   localparam int OP_SUBI = 19;
   localparam int OP_MUL  = 20;

   typedef enum logic {RUN, MUL} state_t;

   function automatic logic [OPC_W-1:0] onehot(input int idx);
      return OPC_W'(1) << idx;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, low WIDTH bits of a*b
// The last partial product is added combinationally so WIDTH steps fit in WIDTH cycles.
module alu_mul_iter #(
   parameter int WIDTH = 32,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             run,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [CW-1:0]    cnt,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (run && !done) begin
         acc    <= acc + (mplier[0] ? mcand : '0);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
      end
   end

   assign done    = (cnt == CW'(WIDTH - 1));
   assign product = acc + (mplier[0] ? mcand : '0);

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked execute-stage ALU with registered result and flags
// Optional iterative multiplier on opcode bit 20 when ALU_MUL_EN is defined.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5,
   parameter int OPC_W = alu_pkg::OPC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPC_W-1:0] opc,
   input  logic [WIDTH-1:0] drs1,
   input  logic [WIDTH-1:0] drs2,
   input  logic [WIDTH-1:0] dimm,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic [TAG_W-1:0] tag_out,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_err
);
   import alu_pkg::*;

   localparam int SH_W = $clog2(WIDTH);
   localparam int M    = WIDTH - 1;

   state_t           state, state_d;
   logic             load_ok, accept;
   logic             mul_start, mul_exit;
   logic [M:0]       mul_prod;
   logic [TAG_W-1:0] mul_tag;

   logic [M:0]       opa, opb, lres, res_d;
   logic [WIDTH:0]   ext;
   logic             sub, arith, err_d, is_mul, c_d, v_d;

   assign load_ok   = !out_valid || out_ready;
   assign in_ready  = (state == RUN) && load_ok;
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && is_mul;

   always_comb begin
      opa    = drs1;
      opb    = drs2;
      sub    = 1'b0;
      arith  = 1'b0;
      lres   = '0;
      err_d  = 1'b0;
      is_mul = 1'b0;
      case (opc)
         onehot(OP_ADD):  arith = 1'b1;
         onehot(OP_SUB):  begin arith = 1'b1; sub = 1'b1; end
         onehot(OP_SADR): begin arith = 1'b1; opa = drs2; opb = dimm; end
         onehot(OP_LADR),
         onehot(OP_ADDI): begin arith = 1'b1; opb = dimm; end
         onehot(OP_SUBI): begin arith = 1'b1; sub = 1'b1; opb = dimm; end
         onehot(OP_SGE):  lres = WIDTH'(drs1 >= drs2);
         onehot(OP_SLE):  lres = WIDTH'(drs1 <= drs2);
         onehot(OP_SGT):  lres = WIDTH'(drs1 > drs2);
         onehot(OP_SLT):  lres = WIDTH'(drs1 < drs2);
         onehot(OP_SEQ):  lres = WIDTH'(drs1 == drs2);
         onehot(OP_SNE):  lres = WIDTH'(drs1 != drs2);
         onehot(OP_AND):  lres = drs1 & drs2;
         onehot(OP_OR):   lres = drs1 | drs2;
         onehot(OP_XOR):  lres = drs1 ^ drs2;
         onehot(OP_NOT):  lres = ~drs1;
         onehot(OP_SLI):  lres = drs1 << dimm[SH_W-1:0];
         onehot(OP_SRI):  lres = drs1 >> dimm[SH_W-1:0];
`ifdef ALU_MUL_EN
         onehot(OP_MUL):  is_mul = 1'b1;
`endif
         default:         err_d = 1'b1;
      endcase
   end

   // One shared WIDTH+1 adder; its top bit is carry for adds and borrow for subs.
   assign ext   = sub ? ({1'b0, opa} - {1'b0, opb}) : ({1'b0, opa} + {1'b0, opb});
   assign res_d = arith ? ext[M:0] : lres;
   assign c_d   = arith & ext[WIDTH];
   assign v_d   = arith & (sub ? (opa[M] ^ opb[M]) : ~(opa[M] ^ opb[M])) & (ext[M] ^ opa[M]);

`ifdef ALU_MUL_EN
   logic            mul_done;
   logic [SH_W-1:0] mul_cnt;
   logic            mul_cnt_unused;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .run     (state == MUL),
      .a       (drs1),
      .b       (drs2),
      .cnt     (mul_cnt),
      .done    (mul_done),
      .product (mul_prod)
   );

   assign mul_cnt_unused = ^mul_cnt;
   assign mul_exit       = (state == MUL) && mul_done && load_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            mul_tag <= '0;
      else if (mul_start) mul_tag <= tag_in;
   end
`else
   assign mul_exit = 1'b0;
   assign mul_prod = '0;
   assign mul_tag  = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         RUN:     if (mul_start) state_d = MUL;
         MUL:     if (mul_exit)  state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Illegal ops still produce a result, with every flag but err cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         tag_out   <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
         flag_err  <= 1'b0;
      end else if (accept && !is_mul) begin
         out_valid <= 1'b1;
         dout      <= res_d;
         tag_out   <= tag_in;
         flag_z    <= (res_d == '0) && !err_d;
         flag_c    <= c_d;
         flag_v    <= v_d;
         flag_err  <= err_d;
      end else if (mul_exit) begin
         out_valid <= 1'b1;
         dout      <= mul_prod;
         tag_out   <= mul_tag;
         flag_z    <= (mul_prod == '0);
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
         flag_err  <= 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (honours ALU_MUL_EN)
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [23:0] opc;
   logic [31:0] drs1, drs2, dimm, dout;
   logic [4:0]  tag_in, tag_out;
   logic        flag_z, flag_c, flag_v, flag_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [23:0] o;
      logic [31:0] a, b, i, d;
      logic [3:0]  f;
      logic [4:0]  t;
   } vec_t;
   vec_t vecs[$];

   alu_pipe #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opc(opc), .drs1(drs1), .drs2(drs2), .dimm(dimm), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .tag_out(tag_out),
      .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_err(flag_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add_vec(input logic [23:0] o, input logic [31:0] a, b, i, d,
                          input logic [3:0] f, input logic [4:0] t);
      vec_t v;
      v.o = o; v.a = a; v.b = b; v.i = i; v.d = d; v.f = f; v.t = t;
      vecs.push_back(v);
   endtask

   task automatic issue(input logic [23:0] o, input logic [31:0] a, b, i, input logic [4:0] t);
      @(negedge clk);
      opc = o; drs1 = a; drs2 = b; dimm = i; tag_in = t; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // f packs {z, c, v, err}
   task automatic expect_res(input string tag, input logic [31:0] d, input logic [3:0] f,
                             input logic [4:0] t);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_dout"}, dout, d);
      check({tag, "_flags"}, {flag_z, flag_c, flag_v, flag_err}, f);
      check({tag, "_tag"}, tag_out, t);
   endtask

   task automatic mul_case(input logic [31:0] a, b, p, input logic [4:0] t);
      issue(24'h100000, a, b, 32'd0, t);
`ifdef ALU_MUL_EN
      begin
         int n;
         int hi;
         n  = 0;
         hi = 0;
         while (!out_valid && n < 100) begin
            if (in_ready) hi++;
            @(posedge clk);
            #1;
            n++;
         end
         check("mul_latency", n, 32);
         check("mul_in_ready_high", hi, 0);
         expect_res("mul", p, {(p == 32'd0), 3'b000}, t);
      end
`else
      expect_res("mul_illegal", 32'd0, 4'b0001, t);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      opc = '0; drs1 = '0; drs2 = '0; dimm = '0; tag_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_dout", dout, 32'd0);
      check("rst_tag", tag_out, 5'd0);
      check("rst_flags", {flag_z, flag_c, flag_v, flag_err}, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      add_vec(24'h000001, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h00000000, 4'b1100, 5'd7);
      add_vec(24'h000002, 32'h80000000, 32'd1,        32'd0,        32'h7FFFFFFF, 4'b0010, 5'd2);
      add_vec(24'h000001, 32'h7FFFFFFF, 32'd1,        32'd0,        32'h80000000, 4'b0010, 5'd3);
      add_vec(24'h080000, 32'd1,        32'd0,        32'd2,        32'hFFFFFFFF, 4'b0100, 5'd4);
      add_vec(24'h000004, 32'd0,        32'h100,      32'h20,       32'h00000120, 4'b0000, 5'd5);
      add_vec(24'h000008, 32'h1000,     32'd0,        32'hFFFFFFFF, 32'h00000FFF, 4'b0100, 5'd6);
      add_vec(24'h040000, 32'd10,       32'd0,        32'hFFFFFFFF, 32'd9,        4'b0100, 5'd8);
      add_vec(24'h000100, 32'd3,        32'hFFFFFFFF, 32'd0,        32'd1,        4'b0000, 5'd9);
      add_vec(24'h000080, 32'd3,        32'hFFFFFFFF, 32'd0,        32'd0,        4'b1000, 5'd10);
      add_vec(24'h000020, 32'd5,        32'd5,        32'd0,        32'd1,        4'b0000, 5'd11);
      add_vec(24'h000040, 32'd6,        32'd5,        32'd0,        32'd0,        4'b1000, 5'd12);
      add_vec(24'h000200, 32'd5,        32'd5,        32'd0,        32'd1,        4'b0000, 5'd13);
      add_vec(24'h000400, 32'd6,        32'd5,        32'd0,        32'd1,        4'b0000, 5'd14);
      add_vec(24'h000800, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hF000F000, 4'b0000, 5'd15);
      add_vec(24'h001000, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0,        32'hFFFFF0F0, 4'b0000, 5'd16);
      add_vec(24'h002000, 32'hA5A5A5A5, 32'hFFFF0000, 32'd0,        32'h5A5AA5A5, 4'b0000, 5'd17);
      add_vec(24'h004000, 32'h0F0F0000, 32'd0,        32'd0,        32'hF0F0FFFF, 4'b0000, 5'd18);
      add_vec(24'h010000, 32'd1,        32'd0,        32'h25,       32'h00000020, 4'b0000, 5'd19);
      add_vec(24'h020000, 32'h80000000, 32'd0,        32'h21,       32'h40000000, 4'b0000, 5'd20);
      add_vec(24'h000003, 32'd5,        32'd5,        32'd0,        32'd0,        4'b0001, 5'd21);
      add_vec(24'h000000, 32'd5,        32'd5,        32'd0,        32'd0,        4'b0001, 5'd22);
      add_vec(24'h000010, 32'd5,        32'd5,        32'd0,        32'd0,        4'b0001, 5'd23);
      add_vec(24'h800000, 32'd5,        32'd5,        32'd0,        32'd0,        4'b0001, 5'd24);
      add_vec(24'h000002, 32'd5,        32'd5,        32'd0,        32'd0,        4'b1000, 5'd25);

      foreach (vecs[k]) begin
         issue(vecs[k].o, vecs[k].a, vecs[k].b, vecs[k].i, vecs[k].t);
         expect_res($sformatf("vec%0d", k), vecs[k].d, vecs[k].f, vecs[k].t);
      end

      repeat (2) @(posedge clk);
      #1;
      check("drain_out_valid", out_valid, 1'b0);

      @(negedge clk);
      out_ready = 1'b0;
      opc = 24'h000001; drs1 = 32'd1; drs2 = 32'd2; tag_in = 5'd1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      expect_res("bp_first", 32'd3, 4'b0000, 5'd1);
      @(negedge clk);
      drs1 = 32'd10; drs2 = 32'd20; tag_in = 5'd2;
      repeat (4) begin
         @(posedge clk);
         #1;
         check("bp_hold_dout", dout, 32'd3);
         check("bp_hold_tag", tag_out, 5'd1);
         check("bp_in_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      expect_res("bp_second", 32'd30, 4'b0000, 5'd2);
      @(negedge clk);
      drs1 = 32'd100; drs2 = 32'd200; tag_in = 5'd3;
      @(posedge clk);
      #1;
      expect_res("bp_third", 32'd300, 4'b0000, 5'd3);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_empty", out_valid, 1'b0);

      mul_case(32'd1234, 32'd5678, 32'd7006652, 5'd9);
      mul_case(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 5'd10);
      mul_case(32'h00010000, 32'h00010000, 32'd0, 5'd11);

      @(negedge clk);
      out_ready = 1'b0;
      issue(24'h000001, 32'd4, 32'd4, 32'd0, 5'd12);
      check("rstbp_valid", out_valid, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstbp_out_valid", out_valid, 1'b0);
      check("rstbp_dout", dout, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rstbp_in_ready", in_ready, 1'b1);

`ifdef ALU_MUL_EN
      issue(24'h100000, 32'd1234, 32'd5678, 32'd0, 5'd13);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmul_out_valid", out_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmul_in_ready", in_ready, 1'b1);
      begin
         int stale;
         stale = 0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
         end
         check("rstmul_no_stale", stale, 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
